alu_byte_interface: RTL
=======================

Name: alu_byte_interface

Overview:
- Byte-stream front end for the 8-bit ALU datapath, the counterpart of the operand driver.
- Collects three bytes from a serial receiver: operand A, then operand B, then the opcode. Drives them onto the ALU inputs.
- Captures the ALU result and hands it to a serial transmitter with a start/done handshake.
- Sits between the UART receiver/transmitter pair and the combinational ALU (A, B, Z style ports).

Parameters:
- DATA_W, 8, width of operands, result and serial bytes.
- OP_W, 6, width of the ALU opcode; taken from rx_data[OP_W-1:0].

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_W  byte from receiver; valid only while rx_done=1.
- rx_done  input  1  one-cycle pulse, a new byte is on rx_data.
- alu_a  output  DATA_W  operand A to ALU.
- alu_b  output  DATA_W  operand B to ALU.
- alu_op  output  OP_W  opcode to ALU.
- alu_result  input  DATA_W  combinational ALU result (Z).
- tx_data  output  DATA_W  byte to transmitter, held stable from tx_start until tx_done.
- tx_start  output  1  one-cycle pulse, requests transmission of tx_data.
- tx_done  input  1  one-cycle pulse from transmitter, byte sent.
- busy  output  1  high in EXEC and SEND.
- rx_drop  output  1  one-cycle pulse when a received byte is discarded.

Behaviour:
- Reset (synchronous, has priority over everything):
  - state=WAIT_A.
  - alu_a, alu_b, alu_op, tx_data = 0.
  - tx_start, busy, rx_drop = 0.
  - Reset mid-operation aborts the transaction and discards partial operands; no tx_start follows.
- State machine, registered, one-hot or binary encoding at implementer's choice.
  - WAIT_A: on rx_done, alu_a<=rx_data, go to WAIT_B; otherwise hold.
  - WAIT_B: on rx_done, alu_b<=rx_data, go to WAIT_OP.
  - WAIT_OP: on rx_done, alu_op<=rx_data[OP_W-1:0], go to EXEC. Upper bits are ignored.
  - EXEC: single cycle for the ALU to settle. tx_data<=alu_result, tx_start<=1, go to SEND.
  - SEND: tx_start back to 0 after one cycle. Hold all outputs. On tx_done, go to WAIT_A.
- Latency: with the opcode rx_done high in cycle n, EXEC is cycle n+1 and tx_start is high in cycle n+2 only.
- Operand registers (alu_a, alu_b, alu_op) keep their values after SEND until overwritten by the next byte. The ALU output therefore stays valid between transactions.
- rx_done in EXEC or SEND: byte discarded, rx_drop=1 for the following cycle, no state change.
- tx_done outside SEND: ignored.
- rx_done and tx_done in the same cycle in SEND: return to WAIT_A, the byte is dropped (rx_drop pulses). The byte does not count as the next operand A.
- No timeout. The FSM waits indefinitely in any WAIT or SEND state.
- No arithmetic in this block; widths pass straight through.
- Illegal or unreachable state encodings recover to WAIT_A on the next clock.

Test Plan:
- Reset then idle 10 cycles -> every output is 0, busy=0, no tx_start.
- Basic transaction (bench ALU model = NOR, opcode 6'b100111):
  - Stimulus: bytes 0xCC, 0xF0, 0x27, each as a one-cycle rx_done separated by gaps.
  - Required: alu_a=0xCC, alu_b=0xF0, alu_op=0x27, tx_data=0x03.
  - Required: a single tx_start exactly 2 cycles after the opcode rx_done, busy high until tx_done.
- Back-to-back transactions:
  - Stimulus: second transaction 0xFF, 0x00, 0x27 sent immediately after tx_done.
  - Required: tx_data=0x00, and the first result is not retransmitted.
- Byte during SEND:
  - Stimulus: extra rx_done with 0x55 before tx_done, plus rx_done coincident with tx_done.
  - Required: both bytes dropped with rx_drop pulses; state returns to WAIT_A; alu_a is unchanged until the next byte.
- Reset mid-operation:
  - Stimulus: send 0xAA, 0xBB, assert reset 1 cycle, then send 0x0F, 0xF0, 0x27.
  - Required: outputs cleared on reset; the new transaction completes with tx_data=0x00; no stray tx_start.
- Opcode upper bits: opcode byte 0xE7 -> alu_op=0x27, identical result to the 0x27 case.

Source files
------------

// File: rtl/alu_byte_interface.sv
// alu_byte_interface
//   Byte-stream front end for the 8-bit combinational ALU. Collects operand A,
//   operand B and the opcode as three received bytes, presents them to the ALU,
//   then captures the ALU result and hands it to a serial transmitter.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   rx_data, rx_done      received byte and its one-cycle valid pulse
//   alu_a, alu_b, alu_op  registered ALU operands and opcode
//   alu_result            combinational ALU result (Z)
//   tx_data, tx_start     byte to transmit and its one-cycle request pulse
//   tx_done               one-cycle pulse from transmitter, byte sent
//   busy                  high while executing or waiting for the transmitter
//   rx_drop               one-cycle pulse after a received byte is discarded
module alu_byte_interface #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              rx_drop
);

  typedef enum logic [2:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StExec   = 3'd3,
    StSend   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                rx_drop_q, rx_drop_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_drop_d  = 1'b0;
    case (state_q)
      StWaitA: begin
        if (rx_done) begin
          a_d     = rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (rx_done) begin
          b_d     = rx_data;
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        if (rx_done) begin
          op_d    = rx_data[OP_W-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        // Operands have been stable on the ALU for a full cycle; latch its result.
        tx_data_d  = alu_result;
        tx_start_d = 1'b1;
        rx_drop_d  = rx_done;
        state_d    = StSend;
      end
      StSend: begin
        // A byte arriving with tx_done is still dropped, not taken as the next A.
        rx_drop_d = rx_done;
        if (tx_done) begin
          state_d = StWaitA;
        end
      end
      default: state_d = StWaitA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWaitA;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign rx_drop  = rx_drop_q;
  assign busy     = (state_q == StExec) || (state_q == StSend);

endmodule
